// File: rtl/demux14_pkg.sv
// Shared types for the demux14_seq lane demultiplexer: FSM states, lane index, lane count.
package demux14_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/demux14_lane_decode.sv
// Combinational lane select: round-robin pointer or manual {s1,s0} to a one-hot lane enable.
module demux14_lane_decode
  import demux14_pkg::*;
(
  input  logic             use_ptr,
  input  lane_idx_t        ptr,
  input  logic             s1,
  input  logic             s0,
  output logic [LANES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (use_ptr) onehot[ptr] = 1'b1;
    else         onehot[{s1, s0}] = 1'b1;
  end

endmodule

// File: rtl/demux14_seq.sv
// Frame-based 1:4 demultiplexer: routes beats into lanes A..D until all four are written, then flushes.
// Optional frame parity output enabled by defining DEMUX14_SEQ_PARITY_EN.
module demux14_seq
  import demux14_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             s0,
  input  logic             s1,
  input  logic             auto_mode,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [3:0]       lane_valid,
  output logic             frame_done,
  output logic [7:0]       frame_count,
`ifdef DEMUX14_SEQ_PARITY_EN
  output logic             frame_parity,
`endif
  output state_t           dbg_state
);

  // Handshake: a beat transfers on a rising edge where din_valid and din_ready are both high;
  // while din_ready is low the sender must hold the beat, and nothing is captured.

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [3:0]       mask_q, mask_d;
  lane_idx_t        ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [3:0]       lane_valid_q, lane_valid_d;
  logic             frame_done_q, frame_done_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic [3:0]       mask_next;
  logic [LANES-1:0] lane_we;
  logic             accept;
  logic             use_ptr;
`ifdef DEMUX14_SEQ_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign din_ready = (state_q != FLUSH);
  assign accept    = din_valid & din_ready;
  // The IDLE accept uses the live auto_mode because that is the beat which latches it.
  assign use_ptr   = (state_q == IDLE) ? auto_mode : mode_q;

  demux14_lane_decode u_decode (
    .use_ptr (use_ptr),
    .ptr     (ptr_q),
    .s1      (s1),
    .s0      (s0),
    .onehot  (lane_we)
  );

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    mask_d        = mask_q;
    ptr_d         = ptr_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    lane_valid_d  = '0;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    mask_next     = mask_q | lane_we;
`ifdef DEMUX14_SEQ_PARITY_EN
    parity_d      = parity_q;
`endif
    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (state_q == IDLE) mode_d = auto_mode;
          lane_valid_d = lane_we;
          if (lane_we[0]) a_d = din;
          if (lane_we[1]) b_d = din;
          if (lane_we[2]) c_d = din;
          if (lane_we[3]) d_d = din;
          if (use_ptr) ptr_d = ptr_q + 2'd1;
          if (mask_next == 4'b1111) begin
            state_d       = FLUSH;
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
            mask_d        = '0;
            ptr_d         = '0;
`ifdef DEMUX14_SEQ_PARITY_EN
            parity_d      = ^{a_d, b_d, c_d, d_d};
`endif
          end else begin
            state_d = FILL;
            mask_d  = mask_next;
          end
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      mask_q        <= '0;
      ptr_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      lane_valid_q  <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
`ifdef DEMUX14_SEQ_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      mask_q        <= mask_d;
      ptr_q         <= ptr_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      lane_valid_q  <= lane_valid_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
`ifdef DEMUX14_SEQ_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign C           = c_q;
  assign D           = d_q;
  assign lane_valid  = lane_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign dbg_state   = state_q;
`ifdef DEMUX14_SEQ_PARITY_EN
  assign frame_parity = parity_q;
`endif

endmodule

// File: tb/tb_demux14_seq.sv
// Table-driven bench for demux14_seq plus hand sequences for counter wrap and frame parity.
module tb_demux14_seq;
  import demux14_pkg::*;

`ifdef DEMUX14_SEQ_PARITY_EN
  localparam int W = 2;
`else
  localparam int W = 1;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         s0, s1, auto_mode;
  logic [W-1:0] A, B, C, D;
  logic [3:0]   lane_valid;
  logic         frame_done;
  logic [7:0]   frame_count;
  state_t       dbg_state;
`ifdef DEMUX14_SEQ_PARITY_EN
  logic         frame_parity;
`endif

  always #5 clk = ~clk;

  demux14_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .s0          (s0),
    .s1          (s1),
    .auto_mode   (auto_mode),
    .A           (A),
    .B           (B),
    .C           (C),
    .D           (D),
    .lane_valid  (lane_valid),
    .frame_done  (frame_done),
    .frame_count (frame_count),
`ifdef DEMUX14_SEQ_PARITY_EN
    .frame_parity(frame_parity),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, vld;
    logic [1:0] din, sel;
    logic       auto_m;
    logic       chk_rdy, rdy;
    logic [1:0] a, b, c, d;
    logic [3:0] lv;
    logic       fd;
    logic [7:0] cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] di,
                              input logic [1:0] sl, input logic am, input logic cr,
                              input logic rd, input logic [1:0] ea, input logic [1:0] eb,
                              input logic [1:0] ec, input logic [1:0] ed, input logic [3:0] lv,
                              input logic fd, input logic [7:0] cnt);
    vec_t t;
    t.rst = r; t.vld = v; t.din = di; t.sel = sl; t.auto_m = am;
    t.chk_rdy = cr; t.rdy = rd;
    t.a = ea; t.b = eb; t.c = ec; t.d = ed;
    t.lv = lv; t.fd = fd; t.cnt = cnt;
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic v, input logic [1:0] di,
                       input logic [1:0] sl, input logic am);
    @(negedge clk);
    rst = r; din_valid = v; din = W'(di); {s1, s0} = sl; auto_mode = am;
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] di,
                      input logic [1:0] sl, input logic am);
    drive(r, v, di, sl, am);
    @(posedge clk);
    #1;
  endtask

  int pulses, rdy_low;
  logic [7:0] cnt_at_255;

  initial begin
    rst = 1'b0; din = '0; din_valid = 1'b0; {s1, s0} = 2'b00; auto_mode = 1'b0;

    //             rst vld din sel am  cr rdy  a  b  c  d  lv    fd cnt
    vecs[0]  = mk(1, 0, 0, 0, 1,  0, 0,  0, 0, 0, 0, 4'h0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 0, 1,  1, 1,  1, 0, 0, 0, 4'h1, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 1,  1, 1,  1, 0, 0, 0, 4'h2, 0, 0);
    vecs[3]  = mk(0, 1, 1, 0, 1,  1, 1,  1, 0, 1, 0, 4'h4, 0, 0);
    vecs[4]  = mk(0, 1, 1, 0, 1,  1, 1,  1, 0, 1, 1, 4'h8, 1, 1);
    vecs[5]  = mk(0, 1, 0, 0, 1,  1, 0,  1, 0, 1, 1, 4'h0, 0, 1);
    vecs[6]  = mk(0, 1, 0, 0, 1,  1, 1,  0, 0, 1, 1, 4'h1, 0, 1);
    vecs[7]  = mk(0, 1, 1, 0, 0,  1, 1,  0, 1, 1, 1, 4'h2, 0, 1);
    vecs[8]  = mk(1, 1, 1, 0, 1,  1, 1,  0, 0, 0, 0, 4'h0, 0, 0);
    vecs[9]  = mk(0, 1, 1, 0, 1,  1, 1,  1, 0, 0, 0, 4'h1, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 1,  1, 1,  1, 0, 0, 0, 4'h0, 0, 0);
    vecs[11] = mk(0, 1, 1, 3, 1,  1, 1,  1, 1, 0, 0, 4'h2, 0, 0);
    vecs[12] = mk(0, 1, 1, 0, 0,  1, 1,  1, 1, 1, 0, 4'h4, 0, 0);
    vecs[13] = mk(0, 1, 0, 0, 1,  1, 1,  1, 1, 1, 0, 4'h8, 1, 1);
    vecs[14] = mk(0, 0, 1, 0, 1,  1, 0,  1, 1, 1, 0, 4'h0, 0, 1);
    vecs[15] = mk(0, 1, 1, 0, 0,  1, 1,  1, 1, 1, 0, 4'h1, 0, 1);
    vecs[16] = mk(0, 1, 0, 0, 0,  1, 1,  0, 1, 1, 0, 4'h1, 0, 1);
    vecs[17] = mk(0, 1, 0, 1, 0,  1, 1,  0, 0, 1, 0, 4'h2, 0, 1);
    vecs[18] = mk(0, 1, 1, 2, 1,  1, 1,  0, 0, 1, 0, 4'h4, 0, 1);
    vecs[19] = mk(0, 1, 1, 3, 0,  1, 1,  0, 0, 1, 1, 4'h8, 1, 2);
    vecs[20] = mk(0, 0, 0, 0, 0,  1, 0,  0, 0, 1, 1, 4'h0, 0, 2);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].din, vecs[i].sel, vecs[i].auto_m);
      #1;
      if (vecs[i].chk_rdy) chk($sformatf("v%0d_ready", i), 32'(din_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_A", i), 32'(A), 32'(vecs[i].a));
      chk($sformatf("v%0d_B", i), 32'(B), 32'(vecs[i].b));
      chk($sformatf("v%0d_C", i), 32'(C), 32'(vecs[i].c));
      chk($sformatf("v%0d_D", i), 32'(D), 32'(vecs[i].d));
      chk($sformatf("v%0d_lane_valid", i), 32'(lane_valid), 32'(vecs[i].lv));
      chk($sformatf("v%0d_frame_done", i), 32'(frame_done), 32'(vecs[i].fd));
      chk($sformatf("v%0d_frame_count", i), 32'(frame_count), 32'(vecs[i].cnt));
    end

    // Counter wrap: 256 auto frames with din_valid held high throughout.
    step(1, 0, 0, 0, 1);
    chk("wrap_reset_count", 32'(frame_count), 32'd0);
    pulses = 0; rdy_low = 0; cnt_at_255 = '0;
    for (int cyc = 0; cyc < 256 * 5; cyc++) begin
      drive(0, 1, 2'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1);
      #1;
      if (!din_ready) rdy_low++;
      @(posedge clk);
      #1;
      if (frame_done) begin
        pulses++;
        if (pulses == 255) cnt_at_255 = frame_count;
      end
    end
    chk("wrap_frame_done_pulses", 32'(pulses), 32'd256);
    chk("wrap_ready_low_cycles", 32'(rdy_low), 32'd256);
    chk("wrap_count_at_255", 32'(cnt_at_255), 32'd255);
    chk("wrap_count_final", 32'(frame_count), 32'd0);

`ifdef DEMUX14_SEQ_PARITY_EN
    step(1, 0, 0, 0, 0);
    chk("par_reset", 32'(frame_parity), 32'd0);
    step(0, 1, 2'b01, 0, 0);
    step(0, 1, 2'b11, 1, 0);
    step(0, 1, 2'b00, 2, 0);
    step(0, 1, 2'b10, 3, 0);
    chk("par1_frame_done", 32'(frame_done), 32'd1);
    chk("par1_parity", 32'(frame_parity), 32'd0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 2'b01, 0, 0);
    step(0, 1, 2'b00, 1, 0);
    step(0, 1, 2'b00, 2, 0);
    step(0, 1, 2'b00, 3, 0);
    chk("par2_frame_done", 32'(frame_done), 32'd1);
    chk("par2_parity", 32'(frame_parity), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux14_seq.md
DEMUX14_SEQ -- requirements
Module: demux14_seq

Interface
REQ-001 Parameter: WIDTH, 1, bit width of din and of each lane output.
REQ-002 Port: clk  in  1  single clock; all logic rising-edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: din  in  WIDTH  data beat to route.
REQ-005 Port: din_valid  in  1  beat present on din.
REQ-006 Port: din_ready  out  1  block accepts a beat this cycle.
REQ-007 Port: s0  in  1  lane select LSB (manual mode).
REQ-008 Port: s1  in  1  lane select MSB (manual mode).
REQ-009 Port: auto_mode  in  1  1 = round-robin lane pointer; 0 = lane from {s1,s0}.
REQ-010 Port: A, B, C, D  out  WIDTH each  registered lane outputs; each holds its value until rewritten.
REQ-011 Port: lane_valid  out  4  one-cycle pulse; bit0 = A ... bit3 = D.
REQ-012 Port: frame_done  out  1  one-cycle pulse when a frame completes.
REQ-013 Port: frame_count  out  8  completed-frame counter.

Function
REQ-014 Accept = din_valid & din_ready, sampled on the clk rising edge.
REQ-015 Lane map for sel = {s1,s0}: 00->A, 01->B, 10->C, 11->D.
REQ-016 Latency 1: on accept in cycle N, the addressed lane output and its lane_valid bit update at edge N+1; lane_valid is a single-cycle pulse.
REQ-017 Non-addressed lanes hold their values; at most one lane_valid bit is high in any cycle.
REQ-018 FSM states: IDLE, FILL, FLUSH.
REQ-019 IDLE: din_ready=1; on accept, latch auto_mode into mode register, write lane, go to FILL.
REQ-020 FILL: din_ready=1; on each accept, write lane and set its bit in a 4-bit written mask.
REQ-021 Auto mode: pointer starts at 0 (A), increments on each accept, lane = pointer; s0/s1 ignored.
REQ-022 Manual mode: lane = {s1,s0}; rewriting an already-written lane is legal (value overwritten, lane_valid pulses, mask unchanged).
REQ-023 When the mask becomes 4'b1111 on an accept: go to FLUSH.
REQ-024 FLUSH (exactly 1 cycle): din_ready=0, frame_done=1, frame_count increments, mask and pointer clear, then go to IDLE.
REQ-025 frame_count wraps 255 -> 0 without a flag.
REQ-026 auto_mode changes are ignored outside the IDLE accept; the latched mode holds for the whole frame.
REQ-027 din_valid high while din_ready low: no capture, no state change; the beat is the sender's to hold.
REQ-028 din is don't-care when din_valid is low; lane outputs do not change without an accept.

Reset
REQ-029 On rst high at a clk edge: state=IDLE, A/B/C/D=0, lane_valid=0, frame_done=0, frame_count=0, mask=0, pointer=0, mode=0.
REQ-030 After reset, din_ready=1 in the first cycle.
REQ-031 rst mid-frame discards the partial frame: no frame_done and no count increment.
REQ-032 rst has priority over a simultaneous accept.

Configuration
REQ-033 Macro DEMUX14_SEQ_PARITY_EN: when defined, adds output port frame_parity (1 bit) = XOR of all bits of A, B, C and D after the completing write, registered and valid in the frame_done cycle; 0 at reset.
REQ-034 Without DEMUX14_SEQ_PARITY_EN, the frame_parity port and its logic do not exist; all other behaviour is identical.

Structure
REQ-035 Shared package demux14_pkg holds: the FSM state typedef (IDLE/FILL/FLUSH), the lane index typedef (2 bits) and the constant LANES=4.
REQ-036 One sub-module, demux14_lane_decode: combinational {s1,s0}/pointer -> 4-bit one-hot write enable; the top level instantiates it once.

Verification
REQ-037 Auto fill: WIDTH=1, auto_mode=1, beats 1,0,1,1 -> A=1, B=0, C=1, D=1; lane_valid 0001,0010,0100,1000; frame_done in the following cycle; frame_count=1.
REQ-038 Manual overwrite: sel 00 (din 1), 00 (din 0), 01, 10, 11 -> A=0; frame_done only after the 11 beat; lane_valid pulses for all 5 beats.
REQ-039 Backpressure: din_valid held high through FLUSH -> din_ready=0 for exactly 1 cycle, no capture; capture resumes in IDLE into lane A (auto).
REQ-040 Reset mid-frame: rst after 2 auto beats -> all outputs 0, frame_count unchanged at 0, next beat lands in A.
REQ-041 Wrap: 256 auto frames -> frame_count=0 after the 256th frame_done.
REQ-042 Parity (macro defined): WIDTH=2, A..D = 01,11,00,10 -> frame_parity=0 with frame_done; A..D = 01,00,00,00 -> frame_parity=1.
